// File: rtl/ex_hilo_ctrl.sv
// HI/LO write controller for the EX stage: MTHI/MTLO, pipelined multiply,
// multiply-accumulate and an externally sequenced divider, stalling until done.
module ex_hilo_ctrl #(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 2,
   parameter int OP_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [OP_W-1:0]       alu_op_i,
   input  logic [DATA_W-1:0]     reg1_i,
   input  logic [DATA_W-1:0]     reg2_i,
   input  logic [DATA_W-1:0]     hi_i,
   input  logic [DATA_W-1:0]     lo_i,
   input  logic                  flush_i,
   input  logic [2*DATA_W-1:0]   div_result_i,
   input  logic                  div_ready_i,
   output logic                  div_start_o,
   output logic                  div_signed_o,
   output logic [DATA_W-1:0]     div_op1_o,
   output logic [DATA_W-1:0]     div_op2_o,
   output logic                  div_cancel_o,
   output logic                  stallreq_o,
   output logic                  write_hilo_o,
   output logic [DATA_W-1:0]     hi_o,
   output logic [DATA_W-1:0]     lo_o
);

   localparam logic [OP_W-1:0] EXE_MTHI_OP  = OP_W'(8'h11);
   localparam logic [OP_W-1:0] EXE_MTLO_OP  = OP_W'(8'h13);
   localparam logic [OP_W-1:0] EXE_MULT_OP  = OP_W'(8'h18);
   localparam logic [OP_W-1:0] EXE_MULTU_OP = OP_W'(8'h19);
   localparam logic [OP_W-1:0] EXE_DIV_OP   = OP_W'(8'h1A);
   localparam logic [OP_W-1:0] EXE_DIVU_OP  = OP_W'(8'h1B);
   localparam logic [OP_W-1:0] EXE_MADD_OP  = OP_W'(8'hA6);
   localparam logic [OP_W-1:0] EXE_MADDU_OP = OP_W'(8'hA8);
   localparam logic [OP_W-1:0] EXE_MSUB_OP  = OP_W'(8'hAA);
   localparam logic [OP_W-1:0] EXE_MSUBU_OP = OP_W'(8'hAB);
   localparam int CNT_W = $clog2(MUL_LAT + 1);

   typedef enum logic [2:0] {IDLE, MUL_WAIT, ACC, DIV_WAIT, DONE} state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [DATA_W-1:0]   mul_a_reg, mul_a_next, mul_b_reg, mul_b_next;
   logic                mul_signed_reg, mul_signed_next;
   logic                acc_en_reg, acc_en_next, acc_sub_reg, acc_sub_next;
   logic [2*DATA_W-1:0] res_reg, res_next;
   logic [DATA_W-1:0]   div_op1_reg, div_op1_next, div_op2_reg, div_op2_next;
   logic                div_signed_reg, div_signed_next;

   logic is_mul, is_acc, is_sub, is_smul, is_div;
   always_comb begin
      is_mul  = alu_op_i inside {EXE_MULT_OP, EXE_MULTU_OP, EXE_MADD_OP,
                                 EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};
      is_acc  = alu_op_i inside {EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};
      is_sub  = alu_op_i inside {EXE_MSUB_OP, EXE_MSUBU_OP};
      is_smul = alu_op_i inside {EXE_MULT_OP, EXE_MADD_OP, EXE_MSUB_OP};
      is_div  = alu_op_i inside {EXE_DIV_OP, EXE_DIVU_OP};
   end

   // Extending both operands to 2*DATA_W makes the truncated product exact for
   // signed and unsigned alike; MUL_LAT-1 register stages follow, res_reg is the last.
   logic [2*DATA_W-1:0] mul_a_ext, mul_b_ext;
   logic [2*DATA_W-1:0] stage_in [MUL_LAT];
   assign mul_a_ext   = {{DATA_W{mul_signed_reg & mul_a_reg[DATA_W-1]}}, mul_a_reg};
   assign mul_b_ext   = {{DATA_W{mul_signed_reg & mul_b_reg[DATA_W-1]}}, mul_b_reg};
   assign stage_in[0] = mul_a_ext * mul_b_ext;

   genvar gi;
   generate
      for (gi = 0; gi < MUL_LAT - 1; gi++) begin : g_mul_pipe
         logic [2*DATA_W-1:0] pipe_reg;
         always_ff @(posedge clk) begin
            if (!rst) pipe_reg <= '0;
            else      pipe_reg <= stage_in[gi];
         end
         assign stage_in[gi+1] = pipe_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         mul_a_reg      <= '0;
         mul_b_reg      <= '0;
         mul_signed_reg <= 1'b0;
         acc_en_reg     <= 1'b0;
         acc_sub_reg    <= 1'b0;
         res_reg        <= '0;
         div_op1_reg    <= '0;
         div_op2_reg    <= '0;
         div_signed_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         mul_a_reg      <= mul_a_next;
         mul_b_reg      <= mul_b_next;
         mul_signed_reg <= mul_signed_next;
         acc_en_reg     <= acc_en_next;
         acc_sub_reg    <= acc_sub_next;
         res_reg        <= res_next;
         div_op1_reg    <= div_op1_next;
         div_op2_reg    <= div_op2_next;
         div_signed_reg <= div_signed_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      mul_a_next      = mul_a_reg;
      mul_b_next      = mul_b_reg;
      mul_signed_next = mul_signed_reg;
      acc_en_next     = acc_en_reg;
      acc_sub_next    = acc_sub_reg;
      res_next        = res_reg;
      div_op1_next    = div_op1_reg;
      div_op2_next    = div_op2_reg;
      div_signed_next = div_signed_reg;
      div_start_o     = 1'b0;
      div_cancel_o    = 1'b0;
      stallreq_o      = 1'b0;
      write_hilo_o    = 1'b0;
      hi_o            = '0;
      lo_o            = '0;
      div_signed_o    = div_signed_reg;
      div_op1_o       = div_op1_reg;
      div_op2_o       = div_op2_reg;

      case (state_reg)
         IDLE: begin
            if (!flush_i) begin
               if (alu_op_i == EXE_MTHI_OP) begin
                  write_hilo_o = 1'b1;
                  hi_o         = reg1_i;
                  lo_o         = lo_i;
               end else if (alu_op_i == EXE_MTLO_OP) begin
                  write_hilo_o = 1'b1;
                  hi_o         = hi_i;
                  lo_o         = reg1_i;
               end else if (is_mul) begin
                  stallreq_o      = 1'b1;
                  mul_a_next      = reg1_i;
                  mul_b_next      = reg2_i;
                  mul_signed_next = is_smul;
                  acc_en_next     = is_acc;
                  acc_sub_next    = is_sub;
                  cnt_next        = '0;
                  state_next      = MUL_WAIT;
               end else if (is_div) begin
                  stallreq_o      = 1'b1;
                  div_op1_next    = reg1_i;
                  div_op2_next    = reg2_i;
                  div_signed_next = (alu_op_i == EXE_DIV_OP);
                  state_next      = DIV_WAIT;
               end
            end
         end
         MUL_WAIT: begin
            if (flush_i) begin
               state_next = IDLE;
            end else begin
               stallreq_o = 1'b1;
               cnt_next   = cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_W'(MUL_LAT - 1)) begin
                  res_next   = stage_in[MUL_LAT-1];
                  state_next = acc_en_reg ? ACC : DONE;
               end
            end
         end
         ACC: begin
            if (flush_i) begin
               state_next = IDLE;
            end else begin
               stallreq_o = 1'b1;
               res_next   = acc_sub_reg ? ({hi_i, lo_i} - res_reg) : ({hi_i, lo_i} + res_reg);
               state_next = DONE;
            end
         end
         DIV_WAIT: begin
            if (flush_i) begin
               div_cancel_o = 1'b1;
               state_next   = IDLE;
            end else begin
               stallreq_o  = 1'b1;
               div_start_o = 1'b1;
               if (div_ready_i) begin
                  res_next   = div_result_i;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (!flush_i) begin
               write_hilo_o = 1'b1;
               hi_o         = res_reg[2*DATA_W-1:DATA_W];
               lo_o         = res_reg[DATA_W-1:0];
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Every output is held low while reset is asserted, including the
      // combinational MTHI/MTLO path.
      if (!rst) begin
         div_start_o  = 1'b0;
         div_cancel_o = 1'b0;
         stallreq_o   = 1'b0;
         write_hilo_o = 1'b0;
         hi_o         = '0;
         lo_o         = '0;
         div_signed_o = 1'b0;
         div_op1_o    = '0;
         div_op2_o    = '0;
      end
   end

endmodule

// File: tb/tb_ex_hilo_ctrl.sv
// Directed bench for ex_hilo_ctrl: expected HI/LO writes (with cycle) go into a
// scoreboard queue; a negedge monitor matches every write_hilo_o pulse against it.
module tb_ex_hilo_ctrl;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_MTHI  = 8'h11;
   localparam logic [7:0] OP_MTLO  = 8'h13;
   localparam logic [7:0] OP_MULT  = 8'h18;
   localparam logic [7:0] OP_MULTU = 8'h19;
   localparam logic [7:0] OP_DIV   = 8'h1A;
   localparam logic [7:0] OP_DIVU  = 8'h1B;
   localparam logic [7:0] OP_MADD  = 8'hA6;
   localparam logic [7:0] OP_MADDU = 8'hA8;
   localparam logic [7:0] OP_MSUB  = 8'hAA;
   localparam logic [7:0] OP_MSUBU = 8'hAB;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  alu_op_i;
   logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
   logic        flush_i;
   logic [63:0] div_result_i;
   logic        div_ready_i;
   logic        div_start_o, div_signed_o, div_cancel_o, stallreq_o, write_hilo_o;
   logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;

   ex_hilo_ctrl #(.DATA_W(32), .MUL_LAT(2), .OP_W(8)) dut (
      .clk(clk), .rst(rst), .alu_op_i(alu_op_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .hi_i(hi_i), .lo_i(lo_i), .flush_i(flush_i), .div_result_i(div_result_i),
      .div_ready_i(div_ready_i), .div_start_o(div_start_o), .div_signed_o(div_signed_o),
      .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_cancel_o(div_cancel_o),
      .stallreq_o(stallreq_o), .write_hilo_o(write_hilo_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [31:0] hi, input logic [31:0] lo);
      exp_t e;
      e.cyc = c;
      e.hi  = hi;
      e.lo  = lo;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write must match the head of the scoreboard in cycle and data.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missing_write: no write at cycle %0d, expected hi=%h lo=%h", e.cyc, e.hi, e.lo);
      end
      if (write_hilo_o) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: cycle %0d hi=%h lo=%h, none required", cyc, hi_o, lo_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc || hi_o !== e.hi || lo_o !== e.lo) begin
               n_fail++;
               $display("FAIL hilo_write: cycle %0d hi=%h lo=%h, required cycle %0d hi=%h lo=%h",
                        cyc, hi_o, lo_o, e.cyc, e.hi, e.lo);
            end else begin
               $display("write cycle %0d hi=%h lo=%h ok", cyc, hi_o, lo_o);
            end
         end
      end
   end

   // Multiply-family op held until its DONE cycle; lat is cycles from op to write.
   task automatic run_mul(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      step();
      alu_op_i = op; reg1_i = a; reg2_i = b; hi_i = hi; lo_i = lo;
      push(cyc + lat, exp_hi, exp_lo);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         check("stall_mul", 64'(stallreq_o), 64'd1);
         step();
      end
      @(negedge clk);
      check("stall_done", 64'(stallreq_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; alu_op_i = OP_MTHI; reg1_i = 32'h55555555; reg2_i = '0;
      hi_i = '0; lo_i = '0; flush_i = 1'b0; div_result_i = '0; div_ready_i = 1'b0;

      // Reset: outputs forced low even with MTHI on the input.
      repeat (3) step();
      @(negedge clk);
      check("rst_write", 64'(write_hilo_o), 64'd0);
      check("rst_hi", 64'(hi_o), 64'd0);
      check("rst_stall", 64'(stallreq_o), 64'd0);
      step();
      rst = 1'b1; alu_op_i = OP_NOP;

      // MTHI: same-cycle write.
      step();
      alu_op_i = OP_MTHI; reg1_i = 32'h12345678; hi_i = '0; lo_i = 32'hAAAA0000;
      push(cyc, 32'h12345678, 32'hAAAA0000);
      @(negedge clk);
      check("mthi_stall", 64'(stallreq_o), 64'd0);
      step();
      alu_op_i = OP_NOP;

      // Multiply family, back to back.
      run_mul(OP_MULT,  32'hFFFFFFFF, 32'd5, 32'd0, 32'd0, 3, 32'hFFFFFFFF, 32'hFFFFFFFB);
      run_mul(OP_MULTU, 32'hFFFFFFFF, 32'd5, 32'd0, 32'd0, 3, 32'h00000004, 32'hFFFFFFFB);
      run_mul(OP_MSUBU, 32'd2, 32'd2, 32'd0, 32'd1, 4, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_mul(OP_MADD,  32'hFFFFFFFE, 32'd3, 32'd0, 32'd10, 4, 32'h0, 32'h4);
      run_mul(OP_MADDU, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 4, 32'h2, 32'h0);
      run_mul(OP_MSUB,  32'hFFFFFFFD, 32'd2, 32'd0, 32'd5, 4, 32'h0, 32'hB);
      step();
      alu_op_i = OP_NOP; hi_i = '0; lo_i = '0;

      // DIVU 7/2 with divider answering at t0+33.
      begin
         int t0;
         step();
         alu_op_i = OP_DIVU; reg1_i = 32'd7; reg2_i = 32'd2;
         t0 = cyc;
         push(t0 + 34, 32'd1, 32'd3);
         @(negedge clk);
         check("divu_start_t0", 64'(div_start_o), 64'd0);
         check("divu_stall_t0", 64'(stallreq_o), 64'd1);
         for (int k = 1; k <= 33; k++) begin
            step();
            if (k == 33) begin
               div_ready_i = 1'b1; div_result_i = {32'd1, 32'd3};
            end
            @(negedge clk);
            check("divu_start", 64'(div_start_o), 64'd1);
            if (k == 1) begin
               check("divu_op1", 64'(div_op1_o), 64'd7);
               check("divu_op2", 64'(div_op2_o), 64'd2);
               check("divu_signed", 64'(div_signed_o), 64'd0);
            end
         end
         step();
         div_ready_i = 1'b0; div_result_i = '0; alu_op_i = OP_NOP;
         @(negedge clk);
         check("divu_start_done", 64'(div_start_o), 64'd0);
         check("divu_stall_done", 64'(stallreq_o), 64'd0);
      end

      // DIV flushed at t0+10 with a coincident ready; then MTLO.
      step();
      alu_op_i = OP_DIV; reg1_i = 32'hFFFFFFF9; reg2_i = 32'd2;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 10) begin
            flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = 64'hDEAD_BEEF_0BAD_F00D;
         end
         @(negedge clk);
         if (k == 1) check("div_signed", 64'(div_signed_o), 64'd1);
         if (k < 10) begin
            check("div_stall", 64'(stallreq_o), 64'd1);
         end else begin
            check("div_cancel", 64'(div_cancel_o), 64'd1);
            check("div_flush_stall", 64'(stallreq_o), 64'd0);
         end
      end
      step();
      flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = '0;
      alu_op_i = OP_MTLO; reg1_i = 32'hCAFEF00D; hi_i = 32'h11112222; lo_i = '0;
      push(cyc, 32'h11112222, 32'hCAFEF00D);
      @(negedge clk);
      check("cancel_pulse_end", 64'(div_cancel_o), 64'd0);
      check("div_start_after_flush", 64'(div_start_o), 64'd0);
      step();
      alu_op_i = OP_NOP; hi_i = '0;

      // Reset during MUL_WAIT abandons the multiply.
      step();
      alu_op_i = OP_MULT; reg1_i = 32'd3; reg2_i = 32'd4;
      @(negedge clk);
      check("mul_pre_rst_stall", 64'(stallreq_o), 64'd1);
      step();
      rst = 1'b0; alu_op_i = OP_NOP;
      @(negedge clk);
      check("midrst_stall", 64'(stallreq_o), 64'd0);
      step();
      rst = 1'b1;
      @(negedge clk);
      check("postrst_idle", 64'(stallreq_o), 64'd0);
      run_mul(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd0, 3, 32'd0, 32'd12);
      step();
      alu_op_i = OP_NOP;

      repeat (5) step();
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_hilo_ctrl.md
# ex_hilo_ctrl

Parametrised HI/LO write controller for the EX stage. It generalises single-cycle HI/LO write selection to multi-cycle operations. It contains its own pipelined multiplier, sequences an external iterative divider through a start/ready handshake, and adds the MADD/MADDU/MSUB/MSUBU accumulate modes. The pipeline is stalled until the 2×DATA_W result is ready, then HI/LO are written with a one-cycle strobe to MEM.

## Interface
- DATA_W, 32, operand and HI/LO register width
- MUL_LAT, 2, multiplier pipeline depth in cycles (≥1)
- OP_W, 8, width of alu_op_i; opcodes are the EXE_*_OP values in defines.v
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge)
- alu_op_i  in  OP_W  EX operation; held stable by the pipeline while stallreq_o=1
- reg1_i, reg2_i  in  DATA_W  operands (rs, rt)
- hi_i, lo_i  in  DATA_W  current HI/LO, already forwarded from MEM/WB
- flush_i  in  1  exception/branch flush of the EX instruction
- div_result_i  in  2*DATA_W  {remainder, quotient} from the divider
- div_ready_i  in  1  divider result valid (one-cycle pulse)
- div_start_o  out  1  request divider; held until div_ready_i
- div_signed_o  out  1  1 for DIV, 0 for DIVU
- div_op1_o, div_op2_o  out  DATA_W  dividend, divisor (registered at start)
- div_cancel_o  out  1  one-cycle abort pulse to the divider on flush
- stallreq_o  out  1  stall request to the pipeline controller
- write_hilo_o  out  1  HI/LO write enable to MEM
- hi_o, lo_o  out  DATA_W  HI/LO write data

## Operation
- States: IDLE, MUL_WAIT, ACC, DIV_WAIT, DONE.
- IDLE:
  - MTHI: write_hilo_o=1, hi_o=reg1_i, lo_o=lo_i. Combinational, no stall.
  - MTLO: write_hilo_o=1, hi_o=hi_i, lo_o=reg1_i. Combinational, no stall.
  - MULT/MULTU/MADD/MADDU/MSUB/MSUBU: latch the operands and signedness, stallreq_o=1, go to MUL_WAIT with cnt=0.
  - DIV/DIVU: latch the operands, stallreq_o=1, go to DIV_WAIT.
  - Any other op: outputs 0.
- MUL_WAIT:
  - cnt increments each cycle.
  - When cnt==MUL_LAT-1, the product is valid and registered. Go to ACC for the accumulate ops; otherwise go to DONE.
  - Signed ops produce the exact two's-complement 2·DATA_W product. Unsigned ops zero-extend.
- ACC:
  - res = {hi_i,lo_i} + prod for MADD/MADDU, or {hi_i,lo_i} − prod for MSUB/MSUBU.
  - Arithmetic is modulo 2^(2·DATA_W); carry/borrow is discarded.
  - Register res, go to DONE.
- DIV_WAIT:
  - div_start_o=1 until div_ready_i.
  - On div_ready_i, register div_result_i and go to DONE.
  - Divide-by-zero is the divider's concern; whatever it returns is written.
- DONE:
  - write_hilo_o=1, {hi_o,lo_o}=registered result, stallreq_o=0.
  - Next state is IDLE.
- stallreq_o=1 in IDLE when a multi-cycle op is decoded, and in MUL_WAIT, ACC and DIV_WAIT.
- Flush:
  - flush_i in any state forces IDLE next cycle, write_hilo_o=0 that cycle, stallreq_o=0.
  - In DIV_WAIT, div_cancel_o=1 for that cycle.
  - A div_ready_i arriving in the same cycle as the flush is discarded.
- Reset: state=IDLE, cnt=0, all registered results 0. All outputs are 0 while rst==0.

## Timing
- MTHI/MTLO: 0 extra cycles; the write appears in the same cycle as the op.
- MULT/MULTU: op seen at t0. The write is at t0+MUL_LAT+1, with stallreq_o=1 for t0..t0+MUL_LAT.
- MADD/MSUB family: write at t0+MUL_LAT+2.
- DIV/DIVU: write one cycle after div_ready_i.
- div_start_o rises at t0+1.
- write_hilo_o is a single-cycle pulse per instruction and never fires on a flushed instruction.
- Back-to-back multi-cycle ops: the op following DONE is decoded in IDLE on the very next cycle; no bubble is required.
- Reset mid-operation: abandons the op with no write. div_cancel_o is not asserted; the divider has its own reset.

## Test plan
- MTHI, reg1_i=0x12345678, lo_i=0xAAAA0000 -> same cycle: write_hilo_o=1, hi_o=0x12345678, lo_o=0xAAAA0000, stallreq_o=0.
- MULT with MUL_LAT=2, reg1_i=0xFFFFFFFF (−1), reg2_i=5 -> stall for 3 cycles, then hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFB. MULTU on the same operands -> hi_o=0x00000004, lo_o=0xFFFFFFFB.
- MSUBU, hi_i=0, lo_i=1, reg1_i=reg2_i=2 -> write at t0+4 with {hi_o,lo_o}=0xFFFFFFFF_FFFFFFFD (wrap-around).
- DIVU 7/2, divider model asserts div_ready_i at t0+33 with result {1,3} -> div_start_o high t0+1..t0+33, write at t0+34 with hi_o=1, lo_o=3.
- DIV in progress, flush_i at t0+10 -> div_cancel_o pulse at t0+10, no write_hilo_o, IDLE at t0+11. A following MTLO writes normally.
- rst=0 asserted during MUL_WAIT -> next edge all outputs 0 and state IDLE. After release, a MULT of 3×4 gives lo_o=12.
